jtag_host: RTL

JTAG_HOST -- requirements
Module: jtag_host

---
 rtl/jtag_host_pkg.sv | 26 ++
 rtl/jtag_host_tck_gen.sv | 36 +++
 rtl/jtag_host.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/jtag_host_pkg.sv
// Shared constants for the JTAG host: command codes, FSM encodings and TMS phase lengths.
package jtag_host_pkg;

   localparam logic [1:0] CmdReset   = 2'd0;
   localparam logic [1:0] CmdIrScan  = 2'd1;
   localparam logic [1:0] CmdDrScan  = 2'd2;
   localparam logic [1:0] CmdRunIdle = 2'd3;

   localparam logic [2:0] StIdle     = 3'd0;
   localparam logic [2:0] StResetSeq = 3'd1;
   localparam logic [2:0] StHeader   = 3'd2;
   localparam logic [2:0] StShift    = 3'd3;
   localparam logic [2:0] StTrailer  = 3'd4;
   localparam logic [2:0] StDone     = 3'd5;

   localparam int unsigned ResetTmsLen = 6;
   localparam int unsigned IrHeaderLen = 4;
   localparam int unsigned DrHeaderLen = 3;
   localparam int unsigned TrailerLen  = 2;

   // Header TMS pattern: IR is 1,1,0,0 and DR is 1,0,0 (Run-Test/Idle to Shift-xR).
   function automatic logic headerTms(input logic isIr, input logic [5:0] idx);
      return isIr ? (idx < 6'd2) : (idx == 6'd0);
   endfunction

endpackage

// File: rtl/jtag_host_tck_gen.sv
// TCK divider: HALF_PERIOD clk cycles low then high while run is set; strobes mark the
// clk edge that will drive TCK high (tckRise) or low (tckFall).
module jtag_host_tck_gen #(
   parameter int unsigned HALF_PERIOD = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tckFall,
   output logic tckRise,
   output logic jtag_tck
);

   logic [7:0] divCnt;
   logic       halfDone;

   assign halfDone = run && (divCnt == 8'(HALF_PERIOD - 1));
   assign tckRise  = halfDone && !jtag_tck;
   assign tckFall  = halfDone && jtag_tck;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         divCnt   <= 8'd0;
         jtag_tck <= 1'b0;
      end else if (!run) begin
         divCnt   <= 8'd0;
         jtag_tck <= 1'b0;
      end else if (halfDone) begin
         divCnt   <= 8'd0;
         jtag_tck <= !jtag_tck;
      end else begin
         divCnt <= divCnt + 8'd1;
      end
   end

endmodule

// File: rtl/jtag_host.sv
// JTAG host: runs RESET / IR_SCAN / DR_SCAN / RUN_IDLE commands on the TAP, inserting a TAP
// reset automatically until the TAP state is known.
module jtag_host
   import jtag_host_pkg::*;
#(
   parameter int unsigned HALF_PERIOD = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_type,
   input  logic [4:0]  cmd_length,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic        jtag_tck,
   output logic        jtag_tms,
   output logic        jtag_tdi,
   input  logic        jtag_tdo
);

   logic [2:0]  state;
   logic [1:0]  cmdType;
   logic [5:0]  len;
   logic [5:0]  cnt;
   logic [31:0] data;
   logic [31:0] capture;
   logic        tapKnown;
   logic        tckFall;
   logic        tckRise;
   logic        run;
   logic        isIr;
   logic        isRunIdle;
   logic [5:0]  cmdLen;
   logic [5:0]  hdrLast;

   assign run       = state inside {StResetSeq, StHeader, StShift, StTrailer};
   assign cmd_ready = (state == StIdle);
   assign busy      = !cmd_ready;
   assign rsp_valid = (state == StDone);
   assign cmdLen    = (cmd_length == 5'd0) ? 6'd32 : {1'b0, cmd_length};
   assign isIr      = (cmdType == CmdIrScan);
   assign isRunIdle = (cmdType == CmdRunIdle);
   assign hdrLast   = isIr ? 6'(IrHeaderLen - 1) : 6'(DrHeaderLen - 1);

   jtag_host_tck_gen #(
      .HALF_PERIOD(HALF_PERIOD)
   ) u_tck_gen (
      .clk     (clk),
      .rst     (rst),
      .run     (run),
      .tckFall (tckFall),
      .tckRise (tckRise),
      .jtag_tck(jtag_tck)
   );

   // TMS/TDI for the next TCK are set on the edge that ends the current one (tckFall).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= StIdle;
         cmdType  <= CmdReset;
         len      <= 6'd0;
         cnt      <= 6'd0;
         data     <= 32'd0;
         capture  <= 32'd0;
         tapKnown <= 1'b0;
         rsp_data <= 32'd0;
         jtag_tms <= 1'b1;
         jtag_tdi <= 1'b0;
      end else begin
         if (tckRise && state == StShift && !isRunIdle) begin
            capture[cnt[4:0]] <= jtag_tdo;
         end
         case (state)
            StIdle: begin
               if (cmd_valid) begin
                  cmdType  <= cmd_type;
                  len      <= cmdLen;
                  data     <= cmd_data;
                  capture  <= 32'd0;
                  cnt      <= 6'd0;
                  jtag_tdi <= 1'b0;
                  if (cmd_type == CmdReset || !tapKnown) begin
                     state    <= StResetSeq;
                     jtag_tms <= 1'b1;
                  end else if (cmd_type == CmdRunIdle) begin
                     state    <= StShift;
                     jtag_tms <= 1'b0;
                  end else begin
                     state    <= StHeader;
                     jtag_tms <= 1'b1;
                  end
               end
            end
            StResetSeq: begin
               if (tckFall) begin
                  if (cnt == 6'(ResetTmsLen - 1)) begin
                     tapKnown <= 1'b1;
                     cnt      <= 6'd0;
                     if (cmdType == CmdReset) begin
                        state    <= StDone;
                        rsp_data <= capture;
                     end else if (isRunIdle) begin
                        state    <= StShift;
                        jtag_tms <= 1'b0;
                     end else begin
                        state    <= StHeader;
                        jtag_tms <= 1'b1;
                     end
                  end else begin
                     cnt      <= cnt + 6'd1;
                     jtag_tms <= (cnt + 6'd1 < 6'(ResetTmsLen - 1));
                  end
               end
            end
            StHeader: begin
               if (tckFall) begin
                  if (cnt == hdrLast) begin
                     state    <= StShift;
                     cnt      <= 6'd0;
                     jtag_tms <= (len == 6'd1);
                     jtag_tdi <= data[0];
                  end else begin
                     cnt      <= cnt + 6'd1;
                     jtag_tms <= headerTms(isIr, cnt + 6'd1);
                  end
               end
            end
            StShift: begin
               if (tckFall) begin
                  if (cnt == len - 6'd1) begin
                     cnt      <= 6'd0;
                     jtag_tdi <= 1'b0;
                     if (isRunIdle) begin
                        state    <= StDone;
                        rsp_data <= capture;
                     end else begin
                        state    <= StTrailer;
                        jtag_tms <= 1'b1;
                     end
                  end else begin
                     cnt      <= cnt + 6'd1;
                     jtag_tdi <= !isRunIdle && data[cnt[4:0] + 5'd1];
                     jtag_tms <= !isRunIdle && (cnt + 6'd2 == len);
                  end
               end
            end
            StTrailer: begin
               if (tckFall) begin
                  if (cnt == 6'(TrailerLen - 1)) begin
                     state    <= StDone;
                     cnt      <= 6'd0;
                     rsp_data <= capture;
                  end else begin
                     cnt      <= cnt + 6'd1;
                     jtag_tms <= 1'b0;
                  end
               end
            end
            StDone:  state <= StIdle;
            default: state <= StIdle;
         endcase
      end
   end

endmodule
